cpu_ctrl: RTL and testbench

Multi-cycle instruction sequencer for the simple CPU. It fetches 8-bit instructions from program memory, decodes them, and drives the ALU mode/function lines (`m`, `s`), the register-file selects and write strobes, and the PC increment/load strobes. It latches the ALU carry/zero outputs for conditional jumps. It sits between program memory, the register file/PC, and the `alu` block.

---
 rtl/cpu_ctrl.sv | 152 +++++++++++++++
 tb/tb_cpu_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl.sv
// Multi-cycle instruction sequencer: fetches 8-bit instructions, decodes them and
// drives ALU select lines, register-file selects/strobes and PC strobes.
module cpu_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] mem_data,
  input  logic       cf,
  input  logic       zf,
  output logic       mem_rd,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       alu_m,
  output logic [3:0] alu_s,
  output logic [1:0] rd_sel,
  output logic [1:0] rs_sel,
  output logic       b_sel,
  output logic [7:0] imm,
  output logic       reg_we,
  output logic       out_we,
  output logic       cflag,
  output logic       zflag,
  output logic       halted
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, FETCH2, EXEC, HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_MOV  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_LDI  = 4'b0110;
  localparam logic [3:0] OP_OUT  = 4'b0111;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_JC   = 4'b1001;
  localparam logic [3:0] OP_JZ   = 4'b1010;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t     state_reg;
  logic [7:0] ir_reg;
  logic [7:0] imm_reg;
  logic       cflag_reg;
  logic       zflag_reg;

  logic [3:0] op;
  logic       is_jump;
  logic       two_byte;
  logic       jump_taken;

  assign op         = ir_reg[7:4];
  assign is_jump    = (op == OP_JMP) || (op == OP_JC) || (op == OP_JZ);
  assign two_byte   = is_jump || (op == OP_LDI);
  // Conditional jumps see the flags as latched before FETCH2, so a flag-setting
  // EXEC immediately ahead of the jump is already visible here.
  assign jump_taken = (op == OP_JMP) || ((op == OP_JC) && cflag_reg) ||
                      ((op == OP_JZ) && zflag_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ir_reg    <= 8'h00;
      imm_reg   <= 8'h00;
      cflag_reg <= 1'b0;
      zflag_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) state_reg <= FETCH;
        end
        FETCH: begin
          ir_reg    <= mem_data;
          state_reg <= DECODE;
        end
        DECODE: begin
          if (op == OP_HALT)  state_reg <= HALT;
          else if (two_byte)  state_reg <= FETCH2;
          else                state_reg <= EXEC;
        end
        FETCH2: begin
          if (op == OP_LDI) begin
            imm_reg   <= mem_data;
            state_reg <= EXEC;
          end else begin
            state_reg <= FETCH;
          end
        end
        EXEC: begin
          if ((op == OP_ADD) || (op == OP_SUB)) begin
            cflag_reg <= cf;
            zflag_reg <= zf;
          end
          state_reg <= FETCH;
        end
        HALT: state_reg <= HALT;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_rd  = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    alu_m   = 1'b0;
    alu_s   = 4'b0000;
    b_sel   = 1'b0;
    reg_we  = 1'b0;
    out_we  = 1'b0;
    case (state_reg)
      FETCH: begin
        mem_rd = 1'b1;
        pc_inc = 1'b1;
      end
      FETCH2: begin
        mem_rd = 1'b1;
        if (is_jump && jump_taken) pc_load = 1'b1;
        else                       pc_inc  = 1'b1;
      end
      EXEC: begin
        case (op)
          OP_MOV: begin alu_m = 1'b1; alu_s = 4'b1010; reg_we = 1'b1; end
          OP_ADD: begin alu_m = 1'b1; alu_s = 4'b1001; reg_we = 1'b1; end
          OP_SUB: begin alu_m = 1'b1; alu_s = 4'b0110; reg_we = 1'b1; end
          OP_AND: begin alu_m = 1'b1; alu_s = 4'b1011; reg_we = 1'b1; end
          OP_NOT: begin alu_m = 1'b1; alu_s = 4'b0101; reg_we = 1'b1; end
          OP_LDI: begin
            alu_m  = 1'b1;
            alu_s  = 4'b1010;
            b_sel  = 1'b1;
            reg_we = 1'b1;
          end
          OP_OUT: begin alu_m = 1'b0; alu_s = 4'b1100; out_we = 1'b1; end
          OP_NOP: ;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign rd_sel = ir_reg[1:0];
  assign rs_sel = ir_reg[3:2];
  assign imm    = imm_reg;
  assign cflag  = cflag_reg;
  assign zflag  = zflag_reg;
  assign halted = (state_reg == HALT);

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: an instruction-level reference model expands
// each instruction into its expected per-cycle outputs; the bench also plays PC/memory.
module tb_cpu_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] mem_data;
  logic       cf = 1'b0;
  logic       zf = 1'b0;
  logic       mem_rd, pc_inc, pc_load, alu_m, b_sel, reg_we, out_we;
  logic       cflag, zflag, halted;
  logic [3:0] alu_s;
  logic [1:0] rd_sel, rs_sel;
  logic [7:0] imm;

  logic [7:0] mem [256];
  logic [7:0] pc = 8'h00;

  // reference model state
  logic [7:0] m_ir, m_imm, mpc;
  logic       m_cf, m_zf;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;
  assign mem_data = mem[pc];

  cpu_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mem_data(mem_data), .cf(cf), .zf(zf),
    .mem_rd(mem_rd), .pc_inc(pc_inc), .pc_load(pc_load), .alu_m(alu_m),
    .alu_s(alu_s), .rd_sel(rd_sel), .rs_sel(rs_sel), .b_sel(b_sel), .imm(imm),
    .reg_we(reg_we), .out_we(out_we), .cflag(cflag), .zflag(zflag), .halted(halted)
  );

  wire [17:0] obs = {mem_rd, pc_inc, pc_load, alu_m, alu_s, rd_sel, rs_sel,
                     b_sel, reg_we, out_we, cflag, zflag, halted};

  function automatic logic [17:0] mk(input logic mrd, input logic inc, input logic ld,
                                     input logic m, input logic [3:0] s, input logic b,
                                     input logic we, input logic ow, input logic h);
    return {mrd, inc, ld, m, s, m_ir[1:0], m_ir[3:2], b, we, ow, m_cf, m_zf, h};
  endfunction

  task automatic model_reset();
    m_ir = 8'h00; m_imm = 8'h00; m_cf = 1'b0; m_zf = 1'b0; mpc = 8'h00; pc = 8'h00;
  endtask

  // One clock cycle: drive inputs after the falling edge, compare, then play the PC.
  task automatic cyc(input logic [17:0] exp, input logic [7:0] eimm, input logic c,
                     input logic z, input logic st, input string nm);
    logic inc, ld;
    logic [7:0] d;
    @(negedge clk);
    start = st; cf = c; zf = z;
    #1;
    total++;
    if (obs !== exp || imm !== eimm) begin
      bad++;
      $display("FAIL %s: got outs=%b imm=%h, want outs=%b imm=%h", nm, obs, imm, exp, eimm);
    end
    inc = pc_inc; ld = pc_load; d = mem_data;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (inc) pc = pc + 8'd1;
    else if (ld) pc = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    total++;
    if (obs !== 18'h0 || imm !== 8'h00) begin
      bad++;
      $display("FAIL reset_values: got outs=%b imm=%h, want all zero", obs, imm);
    end
    #2 rst = 1'b0;
  endtask

  task automatic start_run();
    cyc(mk(0,0,0,0,4'h0,0,0,0,0), m_imm, 1'b0, 1'b0, 1'b1, "idle_start");
  endtask

  // Execute one instruction at mpc; fcf/fzf < 0 means random ALU flags in EXEC.
  task automatic exec_instr(input int fcf, input int fzf, input logic rst_ok);
    logic [7:0] b, b2;
    logic [3:0] op, s;
    logic m, bs, we, ow, c, z, taken;
    b  = mem[mpc];
    b2 = mem[mpc + 8'd1];
    op = b[7:4];
    cyc(mk(1,1,0,0,4'h0,0,0,0,0), m_imm, 1'($urandom), 1'($urandom), rst_ok & 1'($urandom), "fetch");
    m_ir = b;
    mpc  = mpc + 8'd1;
    cyc(mk(0,0,0,0,4'h0,0,0,0,0), m_imm, 1'($urandom), 1'($urandom), rst_ok & 1'($urandom), "decode");
    if (op == 4'hF) begin
      cyc(mk(0,0,0,0,4'h0,0,0,0,1), m_imm, 1'($urandom), 1'($urandom), 1'b0, "halt_enter");
      return;
    end
    if (op == 4'h6) begin
      cyc(mk(1,1,0,0,4'h0,0,0,0,0), m_imm, 1'($urandom), 1'($urandom), rst_ok & 1'($urandom), "fetch2_ldi");
      m_imm = b2;
      mpc   = mpc + 8'd1;
    end else if (op == 4'h8 || op == 4'h9 || op == 4'hA) begin
      taken = (op == 4'h8) || (op == 4'h9 && m_cf) || (op == 4'hA && m_zf);
      cyc(mk(1,!taken,taken,0,4'h0,0,0,0,0), m_imm, 1'($urandom), 1'($urandom), rst_ok & 1'($urandom), "fetch2_jump");
      mpc = taken ? b2 : mpc + 8'd1;
      total++;
      if (pc !== mpc) begin
        bad++;
        $display("FAIL jump_pc: got pc=%h, want %h", pc, mpc);
      end
      return;
    end
    m = 1'b0; s = 4'h0; bs = 1'b0; we = 1'b0; ow = 1'b0;
    case (op)
      4'h1: begin m = 1; s = 4'b1010; we = 1; end
      4'h2: begin m = 1; s = 4'b1001; we = 1; end
      4'h3: begin m = 1; s = 4'b0110; we = 1; end
      4'h4: begin m = 1; s = 4'b1011; we = 1; end
      4'h5: begin m = 1; s = 4'b0101; we = 1; end
      4'h6: begin m = 1; s = 4'b1010; we = 1; bs = 1; end
      4'h7: begin s = 4'b1100; ow = 1; end
      default: ;
    endcase
    c = (fcf < 0) ? 1'($urandom) : 1'(fcf);
    z = (fzf < 0) ? 1'($urandom) : 1'(fzf);
    cyc(mk(0,0,0,m,s,bs,we,ow,0), m_imm, c, z, rst_ok & 1'($urandom), "exec");
    if (op == 4'h2 || op == 4'h3) begin
      m_cf = c; m_zf = z;
    end
    total++;
    if (pc !== mpc) begin
      bad++;
      $display("FAIL exec_pc: got pc=%h, want %h", pc, mpc);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++)
      cyc(mk(0,0,0,0,4'h0,0,0,0,0), m_imm, 1'b1, 1'b1, 1'b0, "idle_hold");
  endtask

  task automatic test_ldi();
    do_reset();
    mem[0] = 8'h61; mem[1] = 8'h05;
    start_run();
    exec_instr(-1, -1, 1'b0);
    total++;
    if (imm !== 8'h05 || rd_sel !== 2'b01) begin
      bad++;
      $display("FAIL ldi_result: got imm=%h rd_sel=%b, want 05 01", imm, rd_sel);
    end
  endtask

  task automatic test_add_mov();
    mem[2] = 8'h24; mem[3] = 8'h14;
    exec_instr(1, 1, 1'b0);
    exec_instr(0, 0, 1'b0);
    total++;
    if (cflag !== 1'b1 || zflag !== 1'b1) begin
      bad++;
      $display("FAIL flags_hold: got c=%b z=%b, want 1 1", cflag, zflag);
    end
  endtask

  task automatic test_jumps();
    do_reset();
    mem[0] = 8'h34; mem[1] = 8'hA0; mem[2] = 8'h20;
    mem[8'h20] = 8'hB3;
    mem[8'h21] = 8'h34; mem[8'h22] = 8'h90; mem[8'h23] = 8'h20;
    start_run();
    exec_instr(0, 1, 1'b0);
    exec_instr(-1, -1, 1'b0);
    total++;
    if (pc !== 8'h20) begin
      bad++;
      $display("FAIL jz_taken: got pc=%h, want 20", pc);
    end
    exec_instr(1, 0, 1'b0);
    total++;
    if (cflag !== 1'b0 || zflag !== 1'b1) begin
      bad++;
      $display("FAIL undef_flags: got c=%b z=%b, want 0 1", cflag, zflag);
    end
    exec_instr(0, 0, 1'b0);
    exec_instr(-1, -1, 1'b0);
    total++;
    if (pc !== 8'h24) begin
      bad++;
      $display("FAIL jc_not_taken: got pc=%h, want 24", pc);
    end
  endtask

  task automatic test_rst_midexec();
    do_reset();
    mem[0] = 8'h24; mem[1] = 8'h24;
    start_run();
    exec_instr(1, 1, 1'b0);
    cyc(mk(1,1,0,0,4'h0,0,0,0,0), m_imm, 1'b0, 1'b0, 1'b0, "fetch_abort");
    m_ir = 8'h24;
    cyc(mk(0,0,0,0,4'h0,0,0,0,0), m_imm, 1'b0, 1'b0, 1'b0, "decode_abort");
    cf = 1'b1; zf = 1'b1;
    #1;
    total++;
    if (reg_we !== 1'b1) begin
      bad++;
      $display("FAIL exec_before_abort: got reg_we=%b, want 1", reg_we);
    end
    rst = 1'b1;
    #1;
    model_reset();
    total++;
    if (obs !== 18'h0 || imm !== 8'h00) begin
      bad++;
      $display("FAIL abort_values: got outs=%b imm=%h, want all zero", obs, imm);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 2; i++)
      cyc(mk(0,0,0,0,4'h0,0,0,0,0), m_imm, 1'b1, 1'b1, 1'b0, "idle_after_abort");
  endtask

  task automatic test_halt();
    do_reset();
    mem[0] = 8'hF0;
    start_run();
    exec_instr(-1, -1, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(mk(0,0,0,0,4'h0,0,0,0,1), m_imm, 1'($urandom), 1'($urandom), 1'b1, "halt_start_ignored");
    do_reset();
    total++;
    if (halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_exit: got halted=%b, want 0", halted);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 8'hEF));
    start_run();
    for (int i = 0; i < 60; i++) exec_instr(-1, -1, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    model_reset();
    test_reset();
    test_ldi();
    test_add_mov();
    test_jumps();
    test_rst_midexec();
    test_halt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end
endmodule
